tex_spi_fetch: RTL and testbench

Texture-fetch controller sitting between the raybox-zero renderer's texture sampler and the external W25Q128-class SPI flash on uio[7:5] (io0..io2) plus uio[0] (/CS) and uio[1] (SCLK).
- Accepts one texel-address request at a time.
- Sequences a Fast Read Dual Output (0x3B) transaction in SPI mode 0.
- Returns one RGB222 texel (6 bits) with a single-cycle valid strobe.
- Owns the tri-state enables so io0 is released before the flash drives it.

---
 rtl/tex_spi_fetch.sv | 129 ++++++++++++
 tb/tb_tex_spi_fetch.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tex_spi_fetch.sv
// Texture-fetch controller: one Fast Read Dual Output (0x3B) SPI flash transaction
// per accepted texel address, returning a DATA_BITS-wide texel with a valid strobe.
module tex_spi_fetch #(
  parameter logic [7:0] CMD        = 8'h3B,
  parameter int         ADDR_W     = 24,
  parameter int         DUMMY_CLKS = 8,
  parameter int         DATA_BITS  = 6,
  parameter int         CS_GAP     = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic [ADDR_W-1:0]     addr,
  output logic                  ready,
  output logic                  data_valid,
  output logic [DATA_BITS-1:0]  data,
  output logic                  spi_csb,
  output logic                  spi_sclk,
  output logic [2:0]            spi_io_out,
  output logic [2:0]            spi_io_oe,
  input  logic [2:0]            spi_io_in
);

  localparam int TX_W = 8 + ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DUMMY,
    S_DATA,
    S_GAP
  } state_t;

  state_t               state;
  logic                 phase_b;
  logic [7:0]           cnt;
  logic [TX_W-1:0]      tx_sh;
  logic [DATA_BITS-1:0] rx_sh;
  logic                 io0_out;
  logic                 io0_oe;
  logic                 unused_io2;

  // io2 is the flash WPn pin and stays driven high; io1 is input-only here.
  assign spi_io_out = {1'b1, 1'b0, io0_out};
  assign spi_io_oe  = {1'b1, 1'b0, io0_oe};
  assign unused_io2 = spi_io_in[2];

  // Each SCLK is phase A (sclk low, io0 updated on entry) then phase B (sclk high);
  // the edge closing phase B is the SCLK falling edge, where dual data is sampled.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      phase_b    <= 1'b0;
      cnt        <= '0;
      tx_sh      <= '0;
      rx_sh      <= '0;
      ready      <= 1'b1;
      data_valid <= 1'b0;
      data       <= '0;
      spi_csb    <= 1'b1;
      spi_sclk   <= 1'b0;
      io0_out    <= 1'b0;
      io0_oe     <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req) begin
            state   <= S_CMD;
            ready   <= 1'b0;
            spi_csb <= 1'b0;
            io0_out <= CMD[7];
            io0_oe  <= 1'b1;
            tx_sh   <= {CMD[6:0], addr, 1'b0};
            phase_b <= 1'b0;
            cnt     <= '0;
          end
        end
        S_GAP: begin
          if (cnt == 8'(CS_GAP - 1)) begin
            state <= S_IDLE;
            ready <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          if (!phase_b) begin
            phase_b  <= 1'b1;
            spi_sclk <= 1'b1;
          end else begin
            phase_b  <= 1'b0;
            spi_sclk <= 1'b0;
            cnt      <= cnt + 8'd1;
            if (state == S_CMD || state == S_ADDR) begin
              io0_out <= tx_sh[TX_W-1];
              tx_sh   <= tx_sh << 1;
            end
            if (state == S_CMD && cnt == 8'd7) begin
              state <= S_ADDR;
              cnt   <= '0;
            end else if (state == S_ADDR && cnt == 8'(ADDR_W - 1)) begin
              // io0 is released before the flash starts driving it
              state   <= S_DUMMY;
              cnt     <= '0;
              io0_oe  <= 1'b0;
              io0_out <= 1'b0;
            end else if (state == S_DUMMY && cnt == 8'(DUMMY_CLKS - 1)) begin
              state <= S_DATA;
              cnt   <= '0;
            end else if (state == S_DATA) begin
              rx_sh <= {rx_sh[DATA_BITS-3:0], spi_io_in[1:0]};
              if (cnt == 8'(DATA_BITS / 2 - 1)) begin
                state      <= S_GAP;
                cnt        <= '0;
                spi_csb    <= 1'b1;
                data_valid <= 1'b1;
                data       <= {rx_sh[DATA_BITS-3:0], spi_io_in[1:0]};
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tex_spi_fetch.sv
// Directed bench for tex_spi_fetch with a behavioural dual-output SPI flash model.
module tb_tex_spi_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic [23:0] addr;
  logic        ready;
  logic        data_valid;
  logic [5:0]  data;
  logic        spi_csb;
  logic        spi_sclk;
  logic [2:0]  spi_io_out;
  logic [2:0]  spi_io_oe;
  logic [2:0]  spi_io_in;

  int checks = 0;
  int errors = 0;

  int          fl_cnt = 0;
  logic [31:0] fl_rx = '0;
  logic [7:0]  fl_cmd = '0;
  logic [23:0] fl_addr = '0;
  logic        fl_oe = 1'b0;
  logic [1:0]  fl_io = 2'b00;
  int          last_rises = 0;
  int          total_rises = 0;
  int          cs_falls = 0;
  int          oe_viol = 0;
  int          contention = 0;
  logic        dummy_entry_oe = 1'b1;
  logic        last_addr_oe = 1'b0;
  logic        prev_csb = 1'b1;
  logic        prev_sclk = 1'b0;

  tex_spi_fetch dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .addr       (addr),
    .ready      (ready),
    .data_valid (data_valid),
    .data       (data),
    .spi_csb    (spi_csb),
    .spi_sclk   (spi_sclk),
    .spi_io_out (spi_io_out),
    .spi_io_oe  (spi_io_oe),
    .spi_io_in  (spi_io_in)
  );

  always #5 clk = ~clk;

  assign spi_io_in = {1'b1,
                      fl_oe ? fl_io[1] : 1'b1,
                      spi_io_oe[0] ? spi_io_out[0] : (fl_oe ? fl_io[0] : 1'b1)};

  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    case (a)
      24'h000123: flash_byte = 8'hB7;
      24'h000010: flash_byte = 8'hFC;
      24'h000011: flash_byte = 8'h03;
      default:    flash_byte = a[7:0] ^ 8'h5A;
    endcase
  endfunction

  // Flash model sampled mid-cycle: captures io0 on SCLK rise, launches pairs on SCLK fall.
  always @(negedge clk) begin
    logic [7:0] b;
    logic [7:0] sh;
    if (spi_sclk && !prev_sclk) total_rises++;
    if (spi_csb) begin
      if (!prev_csb) last_rises = fl_cnt;
      fl_cnt = 0;
      fl_oe  = 1'b0;
    end else begin
      if (prev_csb) cs_falls++;
      if (spi_sclk && !prev_sclk) begin
        if (fl_cnt < 32) fl_rx = {fl_rx[30:0], spi_io_in[0]};
        fl_cnt++;
        if (fl_cnt == 32) begin
          fl_cmd  = fl_rx[31:24];
          fl_addr = fl_rx[23:0];
        end
      end
      if (!spi_sclk && prev_sclk && fl_cnt >= 40 && fl_cnt <= 43) begin
        b     = flash_byte(fl_addr);
        sh    = b >> (6 - 2 * (fl_cnt - 40));
        fl_io = sh[1:0];
        fl_oe = 1'b1;
      end
      if ((fl_cnt > 32 || (fl_cnt == 32 && !spi_sclk)) && spi_io_oe[0]) oe_viol++;
      if (fl_cnt == 32 && !spi_sclk && prev_sclk) dummy_entry_oe = spi_io_oe[0];
      if (fl_cnt == 32 && spi_sclk) last_addr_oe = spi_io_oe[0];
      if (fl_oe && spi_io_oe[0]) contention++;
    end
    prev_csb  = spi_csb;
    prev_sclk = spi_sclk;
  end

  // Waits for ready, presents the request and returns #1 into cycle 1 with req still high.
  task automatic do_accept(input logic [23:0] a, output bit timed_out);
    for (int i = 0; i < 300 && !ready; i++) begin
      @(posedge clk);
      #1;
    end
    timed_out = !ready;
    addr = a;
    req  = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int lat, output bit timed_out);
    lat = 1;
    timed_out = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (data_valid) begin
        timed_out = 1'b0;
        break;
      end
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    req   = 1'b1;
    addr  = 24'h000123;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({ready, data_valid, data, spi_csb, spi_sclk, spi_io_out, spi_io_oe} !==
          {1'b1, 1'b0, 6'd0, 1'b1, 1'b0, 3'b100, 3'b100}) begin
        errors++;
        $display("[TB] FAIL reset_outputs cycle %0d: got rdy=%b dv=%b d=%b csb=%b sclk=%b out=%b oe=%b, expected 1 0 000000 1 0 100 100",
                 i, ready, data_valid, data, spi_csb, spi_sclk, spi_io_out, spi_io_oe);
      end
    end
    checks++;
    if (total_rises !== 0) begin
      errors++;
      $display("[TB] FAIL reset_sclk_edges: got %0d expected 0", total_rises);
    end
    reset = 1'b0;
    req   = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (ready !== 1'b1 || spi_csb !== 1'b1) begin
      errors++;
      $display("[TB] FAIL post_reset_ready: got ready=%b csb=%b expected 1 1", ready, spi_csb);
    end
  endtask

  task automatic test_single_fetch;
    bit to1, to2;
    int lat;
    do_accept(24'h000123, to1);
    req = 1'b0;
    wait_valid(lat, to2);
    checks++;
    if (to1 || to2) begin
      errors++;
      $display("[TB] FAIL single_timeout: got accept_to=%0d valid_to=%0d expected 0 0", to1, to2);
    end
    checks++;
    if (lat !== 87) begin
      errors++;
      $display("[TB] FAIL single_latency: got %0d expected 87", lat);
    end
    checks++;
    if (data !== 6'b101101) begin
      errors++;
      $display("[TB] FAIL single_data: got %b expected 101101", data);
    end
    @(posedge clk);
    #1;
    checks++;
    if (data_valid !== 1'b0 || ready !== 1'b0 || data !== 6'b101101) begin
      errors++;
      $display("[TB] FAIL single_cycle88: got dv=%b ready=%b data=%b expected 0 0 101101", data_valid, ready, data);
    end
    @(posedge clk);
    #1;
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL single_ready_return: got %b expected 1", ready);
    end
    checks++;
    if (fl_cmd !== 8'h3B || fl_addr !== 24'h000123) begin
      errors++;
      $display("[TB] FAIL single_cmd_addr: got cmd=%h addr=%h expected 3b 000123", fl_cmd, fl_addr);
    end
    checks++;
    if (last_rises !== 43) begin
      errors++;
      $display("[TB] FAIL single_sclk_rises: got %0d expected 43", last_rises);
    end
  endtask

  task automatic test_back_to_back;
    bit to;
    int n = 0;
    int run = 0;
    int first_run = -1;
    int dv_cyc[2];
    logic [5:0] dv_data[2];
    int falls0;
    falls0 = cs_falls;
    dv_cyc  = '{0, 0};
    dv_data = '{6'd0, 6'd0};
    do_accept(24'h000010, to);
    addr = 24'h000011;
    for (int cyc = 1; cyc < 250; cyc++) begin
      if (data_valid && n < 2) begin
        dv_cyc[n]  = cyc;
        dv_data[n] = data;
        n++;
        if (n == 2) req = 1'b0;
      end
      if (spi_csb) run++;
      else if (run > 0) begin
        if (first_run < 0) first_run = run;
        run = 0;
      end
      @(posedge clk);
      #1;
    end
    req = 1'b0;
    checks++;
    if (to || n !== 2) begin
      errors++;
      $display("[TB] FAIL b2b_strobes: got %0d strobes (accept_to=%0d) expected 2", n, to);
    end
    checks++;
    if (dv_data[0] !== 6'b111111 || dv_data[1] !== 6'b000000) begin
      errors++;
      $display("[TB] FAIL b2b_data: got %b %b expected 111111 000000", dv_data[0], dv_data[1]);
    end
    checks++;
    if (dv_cyc[1] - dv_cyc[0] !== 89) begin
      errors++;
      $display("[TB] FAIL b2b_period: got %0d expected 89", dv_cyc[1] - dv_cyc[0]);
    end
    checks++;
    if (first_run !== 3) begin
      errors++;
      $display("[TB] FAIL b2b_cs_high: got %0d expected 3", first_run);
    end
    checks++;
    if (cs_falls - falls0 !== 2) begin
      errors++;
      $display("[TB] FAIL b2b_transactions: got %0d expected 2", cs_falls - falls0);
    end
  endtask

  task automatic test_dummy_oe;
    bit to1, to2;
    int lat;
    dummy_entry_oe = 1'b1;
    last_addr_oe   = 1'b0;
    do_accept(24'h000123, to1);
    req = 1'b0;
    wait_valid(lat, to2);
    checks++;
    if (to1 || to2 || last_addr_oe !== 1'b1 || dummy_entry_oe !== 1'b0) begin
      errors++;
      $display("[TB] FAIL oe_boundary: got last_addr_oe=%b dummy_entry_oe=%b to=%0d%0d expected 1 0 00",
               last_addr_oe, dummy_entry_oe, to1, to2);
    end
    checks++;
    if (oe_viol !== 0 || contention !== 0) begin
      errors++;
      $display("[TB] FAIL oe_released: got violations=%0d contention=%0d expected 0 0", oe_viol, contention);
    end
  endtask

  task automatic test_reset_abort;
    bit to1, to2;
    int lat;
    int dv_seen = 0;
    int i;
    do_accept(24'h000123, to1);
    req = 1'b0;
    for (i = 0; i < 200; i++) begin
      @(posedge clk);
      #7;
      if (fl_cnt == 19) break;
    end
    checks++;
    if (to1 || i == 200) begin
      errors++;
      $display("[TB] FAIL abort_reach_addr10: got fl_cnt=%0d expected 19", fl_cnt);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checks++;
    if ({spi_csb, spi_sclk, spi_io_oe, ready, data_valid, data} !== {1'b1, 1'b0, 3'b100, 1'b1, 1'b0, 6'd0}) begin
      errors++;
      $display("[TB] FAIL abort_outputs: got csb=%b sclk=%b oe=%b rdy=%b dv=%b d=%b expected 1 0 100 1 0 000000",
               spi_csb, spi_sclk, spi_io_oe, ready, data_valid, data);
    end
    for (int k = 0; k < 100; k++) begin
      if (data_valid) dv_seen++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (dv_seen !== 0) begin
      errors++;
      $display("[TB] FAIL abort_no_valid: got %0d strobes expected 0", dv_seen);
    end
    do_accept(24'h000123, to1);
    req = 1'b0;
    wait_valid(lat, to2);
    checks++;
    if (to1 || to2 || lat !== 87 || data !== 6'b101101) begin
      errors++;
      $display("[TB] FAIL abort_refetch: got lat=%0d data=%b expected 87 101101", lat, data);
    end
  endtask

  task automatic test_busy_toggle;
    bit to1;
    bit to2 = 1'b1;
    int lat = 0;
    int falls0;
    falls0 = cs_falls;
    do_accept(24'h000010, to1);
    for (int cyc = 1; cyc < 300; cyc++) begin
      if (data_valid) begin
        lat = cyc;
        to2 = 1'b0;
        req = 1'b0;
        break;
      end
      req  = ~req;
      addr = 24'hFFFFFF ^ 24'(cyc * 37);
      @(posedge clk);
      #1;
    end
    req = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (cs_falls - falls0 !== 1) begin
      errors++;
      $display("[TB] FAIL toggle_one_txn: got %0d expected 1", cs_falls - falls0);
    end
    checks++;
    if (to1 || to2 || lat !== 87 || data !== 6'b111111 || fl_addr !== 24'h000010) begin
      errors++;
      $display("[TB] FAIL toggle_captured_addr: got lat=%0d data=%b addr=%h expected 87 111111 000010",
               lat, data, fl_addr);
    end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_back_to_back();
    test_dummy_oe();
    test_reset_abort();
    test_busy_toggle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
